// File: rtl/isa_bus_write_sync.sv
// -----------------------------------------------------------------------------
// isa_bus_write_sync
//   Clocked ISA/PC104 front end for the signal-board CPLD. Synchronises the
//   asynchronous bus strobes, address and data into CLK. It glitch-filters
//   IOW and decodes a window of NUM_REGS 16-bit registers plus one status
//   word at BASE_ADDR. Each accepted host write becomes a valid/ready
//   transaction through a small first-word-fall-through FIFO. Host reads of
//   the registers and of the status word are also served here.
//
// Ports
//   CLK       system clock
//   RST_N     synchronous reset, active low
//   IOW/IOR   ISA write/read strobes, active low, asynchronous to CLK
//   SA        ISA address
//   SD_IN     ISA data from the pad
//   SD_OUT    registered read data to the pad
//   SD_OE     pad output enable (combinational, 1 = drive SD)
//   RD_IDX    register index addressed by the raw SA; valid while SD_OE
//   RD_DATA   register-file value for RD_IDX
//   WR_VALID  write transaction available at the FIFO head
//   WR_READY  consumer accepts the head when WR_VALID && WR_READY at posedge
//   WR_IDX    register index of the head transaction (0 when empty)
//   WR_DATA   data of the head transaction (0 when empty)
//   OVF       sticky: a qualified write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module isa_bus_write_sync #(
  parameter logic [11:0] BASE_ADDR   = 12'h240,
  parameter int          NUM_REGS    = 4,   // >= 2
  parameter int          SYNC_STAGES = 2,   // >= 2
  parameter int          HOLD_MIN    = 2,
  parameter int          FIFO_DEPTH  = 2    // power of 2, >= 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        IOW,
  input  logic                        IOR,
  input  logic [11:0]                 SA,
  input  logic [15:0]                 SD_IN,
  output logic [15:0]                 SD_OUT,
  output logic                        SD_OE,
  output logic [$clog2(NUM_REGS)-1:0] RD_IDX,
  input  logic [15:0]                 RD_DATA,
  output logic                        WR_VALID,
  input  logic                        WR_READY,
  output logic [$clog2(NUM_REGS)-1:0] WR_IDX,
  output logic [15:0]                 WR_DATA,
  output logic                        OVF
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(HOLD_MIN + 1);

  localparam logic [11:0]      LAST_ADDR  = 12'(BASE_ADDR + NUM_REGS);
  localparam logic [11:0]      STATUS_OFF = 12'(NUM_REGS);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MIN - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, ARMED = 2'd2} wr_state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers: all four buses share the same depth so they stay aligned.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]        iow_sync;
  logic [SYNC_STAGES-1:0]        ior_sync;
  logic [SYNC_STAGES-1:0][11:0]  sa_sync;
  logic [SYNC_STAGES-1:0][15:0]  sd_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what a shift chain needs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      iow_sync <= '1;
      ior_sync <= '1;
      sa_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      iow_sync <= {iow_sync[SYNC_STAGES-2:0], IOW};
      ior_sync <= {ior_sync[SYNC_STAGES-2:0], IOR};
      sa_sync  <= {sa_sync[SYNC_STAGES-2:0], SA};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], SD_IN};
    end
  end

  logic        iow_s, ior_s;
  logic [11:0] sa_s, off_s;
  logic [15:0] sd_s;
  logic        hit_s, is_reg_s, is_stat_s;

  assign iow_s     = iow_sync[SYNC_STAGES-1];
  assign ior_s     = ior_sync[SYNC_STAGES-1];
  assign sa_s      = sa_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign off_s     = sa_s - BASE_ADDR;
  assign hit_s     = (sa_s >= BASE_ADDR) && (sa_s <= LAST_ADDR);
  assign is_reg_s  = hit_s && (off_s < STATUS_OFF);
  assign is_stat_s = hit_s && (off_s == STATUS_OFF);

  // ---------------------------------------------------------------------------
  // Write qualifier FSM. The capture is refreshed on every low cycle so the
  // pushed value is the last one sampled before IOW rose.
  // ---------------------------------------------------------------------------
  wr_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] cap_idx;
  logic [15:0]      cap_data;
  logic             cap_ok;    // capture targets a data register
  logic             push;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!iow_s && hit_s) begin
            cnt      <= CNT_W'(1);
            cap_idx  <= off_s[IDX_W-1:0];
            cap_data <= sd_s;
            cap_ok   <= is_reg_s;
            state    <= (HOLD_MIN <= 1) ? ARMED : QUAL;
          end
        end
        QUAL: begin
          if (iow_s) begin
            cap_ok <= 1'b0;        // glitch: discard
            state  <= IDLE;
          end else begin
            cnt      <= cnt + 1'b1;
            cap_idx  <= off_s[IDX_W-1:0];
            cap_data <= sd_s;
            cap_ok   <= is_reg_s;
            if (cnt == HOLD_LAST) state <= ARMED;
          end
        end
        ARMED: begin
          if (iow_s) begin
            state <= IDLE;
          end else begin
            cap_idx  <= off_s[IDX_W-1:0];
            cap_data <= sd_s;
            cap_ok   <= is_reg_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status-address writes never push, so they cannot raise OVF either.
  assign push = (state == ARMED) && iow_s && cap_ok;

  // ---------------------------------------------------------------------------
  // First-word-fall-through write FIFO.
  // ---------------------------------------------------------------------------
  logic [IDX_W+15:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, pop, accept, drop;

  assign full   = (level == LVL_FULL);
  assign pop    = WR_VALID && WR_READY;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // NOTE: the storage array has no reset; the level counter alone defines
  // which entries are meaningful, and the outputs are masked while empty.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= {cap_idx, cap_data};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign WR_VALID = (level != '0);
  assign WR_IDX   = WR_VALID ? mem[rd_ptr][IDX_W+15:16] : '0;
  assign WR_DATA  = WR_VALID ? mem[rd_ptr][15:0]        : '0;

  // ---------------------------------------------------------------------------
  // Sticky overflow. Cleared on the synchronised IOR rising edge that ends a
  // status read; a drop in that same cycle keeps it set.
  // ---------------------------------------------------------------------------
  logic ior_prev, stat_pend, ior_rise;

  assign ior_rise = ior_s && !ior_prev;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OVF       <= 1'b0;
      ior_prev  <= 1'b1;
      stat_pend <= 1'b0;
    end else begin
      ior_prev <= ior_s;
      if (!ior_s && is_stat_s) stat_pend <= 1'b1;
      else if (ior_rise)       stat_pend <= 1'b0;
      if (drop)                        OVF <= 1'b1;
      else if (ior_rise && stat_pend)  OVF <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path works on the raw address so SD is released as soon as IOR rises.
  // ---------------------------------------------------------------------------
  logic [11:0] raw_off;
  logic        raw_hit;
  logic [15:0] status_word;

  assign raw_off     = SA - BASE_ADDR;
  assign raw_hit     = (SA >= BASE_ADDR) && (SA <= LAST_ADDR);
  assign SD_OE       = RST_N && !IOR && raw_hit;
  assign RD_IDX      = raw_off[IDX_W-1:0];
  assign status_word = {OVF, 3'b000, 4'(level), 8'h00};

  always_ff @(posedge CLK) begin
    if (!RST_N)                             SD_OUT <= '0;
    else if (raw_hit && raw_off < STATUS_OFF) SD_OUT <= RD_DATA;
    else if (raw_hit)                       SD_OUT <= status_word;
    else                                    SD_OUT <= '0;
  end

endmodule
